// File: rtl/strobe_meter_pkg.sv
// Shared types and defaults for the strobe_meter pulse-width/gap monitor.
package strobe_meter_pkg;

    localparam int RESULT_CNT_W = 16;
    localparam int DEF_TIMEOUT  = 1000;

    typedef enum logic [1:0] {
        WAIT_LOW = 2'd0,
        LOW_CNT  = 2'd1,
        HIGH_CNT = 2'd2
    } state_t;

    typedef struct packed {
        logic [RESULT_CNT_W-1:0] width;
        logic [RESULT_CNT_W-1:0] gap;
        logic                    first;
        logic                    sat;
    } result_t;

endpackage

// File: rtl/strobe_meter_outreg.sv
// Single-entry valid/ready holding register; a result arriving while the
// held one is stalled is discarded and flagged on the sticky drop output.
module strobe_meter_outreg #(
    parameter int W = 34
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    input  logic [W-1:0] in_data,
    input  logic         out_ready,
    output logic         out_valid,
    output logic [W-1:0] out_data,
    output logic         drop
);

    logic accept;
    logic load;

    assign accept = out_valid && out_ready;
    assign load   = in_valid && (!out_valid || out_ready);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            drop      <= 1'b0;
        end else begin
            if (load) begin
                out_valid <= 1'b1;
                out_data  <= in_data;
            end else if (accept) begin
                out_valid <= 1'b0;
            end
            if (in_valid && !load) begin
                drop <= 1'b1;
            end
        end
    end

endmodule

// File: rtl/strobe_meter.sv
// Measures high width and preceding low gap of each strobe pulse in clk cycles.
// Optional STROBE_METER_SYNC_EN adds a 2-flop synchronizer ahead of the sampler.
module strobe_meter
    import strobe_meter_pkg::*;
#(
    parameter int CNT_W   = 16,
    parameter int TIMEOUT = DEF_TIMEOUT
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             strobe_i,
    output logic             res_valid_o,
    input  logic             res_ready_i,
    output logic [CNT_W-1:0] res_width_o,
    output logic [CNT_W-1:0] res_gap_o,
    output logic             res_first_o,
    output logic             res_sat_o,
    output logic             timeout_o,
    output logic             drop_o
);

    typedef struct packed {
        logic [CNT_W-1:0] width;
        logic [CNT_W-1:0] gap;
        logic             first;
        logic             sat;
    } res_t;

    localparam int               RES_W   = $bits(res_t);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
    localparam logic [CNT_W-1:0] TO_LIM  = CNT_W'(TIMEOUT);

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == CNT_MAX) ? v : v + CNT_ONE;
    endfunction

    logic             s_in, s_in_vld;
    logic             s_q, s_qq, vld_p0;
    logic             rise, fall, emit;
    state_t           state_q, state_d;
    logic [CNT_W-1:0] gap_cnt_q, gap_cnt_d;
    logic [CNT_W-1:0] width_cnt_q, width_cnt_d;
    logic [CNT_W-1:0] gap_lat_q, gap_lat_d;
    logic             first_q, first_d;
    res_t             res_in, res_out;

`ifdef STROBE_METER_SYNC_EN
    logic [1:0] sync_q, sync_vld_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_q     <= '0;
            sync_vld_q <= '0;
        end else begin
            sync_q     <= {sync_q[0], strobe_i};
            sync_vld_q <= {sync_vld_q[0], 1'b1};
        end
    end

    assign s_in     = sync_q[1];
    assign s_in_vld = sync_vld_q[1];
`else
    assign s_in     = strobe_i;
    assign s_in_vld = 1'b1;
`endif

    // Sample stage: vld_p0 marks s_q as a real sample rather than its reset value
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s_q    <= 1'b0;
            s_qq   <= 1'b0;
            vld_p0 <= 1'b0;
        end else begin
            s_q    <= s_in;
            s_qq   <= s_q;
            vld_p0 <= s_in_vld;
        end
    end

    assign rise = s_q & ~s_qq;
    assign fall = ~s_q & s_qq;

    // Measurement stage
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= WAIT_LOW;
            gap_cnt_q   <= '0;
            width_cnt_q <= '0;
            gap_lat_q   <= '0;
            first_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            gap_cnt_q   <= gap_cnt_d;
            width_cnt_q <= width_cnt_d;
            gap_lat_q   <= gap_lat_d;
            first_q     <= first_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        gap_cnt_d   = gap_cnt_q;
        width_cnt_d = width_cnt_q;
        gap_lat_d   = gap_lat_q;
        first_d     = first_q;
        emit        = 1'b0;
        case (state_q)
            WAIT_LOW: begin
                first_d = 1'b1;
                if (vld_p0 && !s_q) begin
                    gap_cnt_d = CNT_ONE;
                    state_d   = LOW_CNT;
                end
            end
            LOW_CNT: begin
                if (rise) begin
                    gap_lat_d   = gap_cnt_q;
                    width_cnt_d = CNT_ONE;
                    state_d     = HIGH_CNT;
                end else if (!s_q) begin
                    gap_cnt_d = sat_inc(gap_cnt_q);
                end
            end
            HIGH_CNT: begin
                if (fall) begin
                    emit      = 1'b1;
                    gap_cnt_d = CNT_ONE;
                    first_d   = 1'b0;
                    state_d   = LOW_CNT;
                end else if (s_q) begin
                    width_cnt_d = sat_inc(width_cnt_q);
                end
            end
            default: state_d = WAIT_LOW;
        endcase
    end

    // Counters stick at all-ones once reached, so a final compare covers the whole pulse
    always_comb begin
        res_in.width = width_cnt_q;
        res_in.gap   = gap_lat_q;
        res_in.first = first_q;
        res_in.sat   = (width_cnt_q == CNT_MAX) || (gap_lat_q == CNT_MAX);
    end

    // WAIT_LOW is left on the first valid low sample, so its low count never
    // reaches TIMEOUT (>=1) and only gap_cnt needs comparing.
    assign timeout_o = (state_q == LOW_CNT) && (gap_cnt_q >= TO_LIM) && !rise;

    // Output stage
    strobe_meter_outreg #(
        .W(RES_W)
    ) u_outreg (
        .clk      (clk),
        .rst      (rst),
        .in_valid (emit),
        .in_data  (res_in),
        .out_ready(res_ready_i),
        .out_valid(res_valid_o),
        .out_data (res_out),
        .drop     (drop_o)
    );

    assign res_width_o = res_out.width;
    assign res_gap_o   = res_out.gap;
    assign res_first_o = res_out.first;
    assign res_sat_o   = res_out.sat;

endmodule

// File: tb/tb_strobe_meter.sv
// Self-checking bench for strobe_meter: a default instance (CNT_W=16) and a
// narrow instance (CNT_W=4, TIMEOUT=10) share strobe, ready and reset.
module tb_strobe_meter;

`ifdef STROBE_METER_SYNC_EN
    localparam int D = 2;
`else
    localparam int D = 0;
`endif
    localparam int NP = 22;

    logic        clk;
    logic        rst;
    logic        strobe;
    logic        ready;
    logic        a_valid, a_first, a_sat, a_timeout, a_drop;
    logic [15:0] a_width, a_gap;
    logic        b_valid, b_first, b_sat, b_timeout, b_drop;
    logic [3:0]  b_width, b_gap;

    int n_tests = 0;
    int n_fail  = 0;

    strobe_meter #(.CNT_W(16), .TIMEOUT(1000)) dut_a (
        .clk(clk), .rst(rst), .strobe_i(strobe),
        .res_valid_o(a_valid), .res_ready_i(ready),
        .res_width_o(a_width), .res_gap_o(a_gap),
        .res_first_o(a_first), .res_sat_o(a_sat),
        .timeout_o(a_timeout), .drop_o(a_drop)
    );

    strobe_meter #(.CNT_W(4), .TIMEOUT(10)) dut_b (
        .clk(clk), .rst(rst), .strobe_i(strobe),
        .res_valid_o(b_valid), .res_ready_i(ready),
        .res_width_o(b_width), .res_gap_o(b_gap),
        .res_first_o(b_first), .res_sat_o(b_sat),
        .timeout_o(b_timeout), .drop_o(b_drop)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic do_reset(input logic s);
        @(negedge clk);
        rst    = 1'b1;
        strobe = s;
        ready  = 1'b1;
        cyc(2);
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; strobe = 1'b0; ready = 1'b0;
        cyc(3);
        n_tests++;
        if ({a_valid, a_width, a_gap, a_first, a_sat, a_timeout, a_drop} !== 36'h0) begin
            n_fail++;
            $display("FAIL reset_a: got %h want 0", {a_valid, a_width, a_gap, a_first, a_sat, a_timeout, a_drop});
        end
        n_tests++;
        if ({b_valid, b_width, b_gap, b_first, b_sat, b_timeout, b_drop} !== 12'h0) begin
            n_fail++;
            $display("FAIL reset_b: got %h want 0", {b_valid, b_width, b_gap, b_first, b_sat, b_timeout, b_drop});
        end
        rst = 1'b0;
        cyc(3); strobe = 1'b1; cyc(2); strobe = 1'b0; cyc(D + 4);
        n_tests++;
        if (a_valid !== 1'b1) begin
            n_fail++; $display("FAIL pre_reset_hold: got %b want 1", a_valid);
        end
        // reset asserted between clock edges must clear outputs immediately
        @(posedge clk); #2; rst = 1'b1; #1;
        n_tests++;
        if ({a_valid, a_width, a_gap, a_first, a_sat, a_timeout, a_drop} !== 36'h0) begin
            n_fail++;
            $display("FAIL async_reset_a: got %h want 0", {a_valid, a_width, a_gap, a_first, a_sat, a_timeout, a_drop});
        end
        @(negedge clk); rst = 1'b0;
    endtask

    task automatic test_single_pulse();
        int lat, nv;
        logic [15:0] w;
        logic f, s;
        lat = -1; nv = 0; w = '0; f = 1'b0; s = 1'b0;
        do_reset(1'b0);
        cyc(5);
        strobe = 1'b1; cyc(3); strobe = 1'b0;
        for (int k = 1; k <= D + 6; k++) begin
            @(negedge clk);
            if (a_valid) begin
                if (lat < 0) begin
                    lat = k; w = a_width; f = a_first; s = a_sat;
                end
                nv++;
            end
        end
        n_tests++;
        if (lat !== D + 2) begin n_fail++; $display("FAIL single_latency: got %0d want %0d", lat, D + 2); end
        n_tests++;
        if (nv !== 1) begin n_fail++; $display("FAIL single_valid_cycles: got %0d want 1", nv); end
        n_tests++;
        if (w !== 16'd3) begin n_fail++; $display("FAIL single_width: got %0d want 3", w); end
        n_tests++;
        if (f !== 1'b1) begin n_fail++; $display("FAIL single_first: got %b want 1", f); end
        n_tests++;
        if (s !== 1'b0) begin n_fail++; $display("FAIL single_sat: got %b want 0", s); end
    endtask

    task automatic test_back_to_back();
        int tw[NP];
        int tg[NP];
        int budget, idx;
        for (int i = 0; i < NP; i++) begin
            if (i < 10) begin
                tw[i] = 4; tg[i] = 7;
            end else if (i < 12) begin
                tw[i] = 1; tg[i] = 1;
            end else begin
                tw[i] = $urandom_range(1, 6); tg[i] = $urandom_range(1, 6);
            end
        end
        budget = D + 10;
        for (int i = 0; i < NP; i++) budget += tw[i] + tg[i];
        idx = 0;
        do_reset(1'b0);
        fork
            begin
                for (int i = 0; i < NP; i++) begin
                    strobe = 1'b0; cyc(tg[i]);
                    strobe = 1'b1; cyc(tw[i]);
                end
                strobe = 1'b0;
            end
            begin
                for (int c = 0; c < budget && idx < NP; c++) begin
                    @(negedge clk);
                    if (a_valid) begin
                        n_tests++;
                        if (a_width !== 16'(tw[idx])) begin
                            n_fail++; $display("FAIL train_width[%0d]: got %0d want %0d", idx, a_width, tw[idx]);
                        end
                        if (idx > 0) begin
                            n_tests++;
                            if (a_gap !== 16'(tg[idx])) begin
                                n_fail++; $display("FAIL train_gap[%0d]: got %0d want %0d", idx, a_gap, tg[idx]);
                            end
                        end
                        n_tests++;
                        if (a_first !== (idx == 0)) begin
                            n_fail++; $display("FAIL train_first[%0d]: got %b want %b", idx, a_first, idx == 0);
                        end
                        n_tests++;
                        if (a_sat !== 1'b0) begin
                            n_fail++; $display("FAIL train_sat[%0d]: got %b want 0", idx, a_sat);
                        end
                        idx++;
                    end
                end
            end
        join
        n_tests++;
        if (idx !== NP) begin n_fail++; $display("FAIL train_count: got %0d want %0d", idx, NP); end
        n_tests++;
        if (a_drop !== 1'b0) begin n_fail++; $display("FAIL train_drop: got %b want 0", a_drop); end
    endtask

    task automatic test_reset_high();
        int nv, nv2;
        logic [15:0] w;
        logic f, s;
        nv = 0; nv2 = 0; w = '0; f = 1'b0; s = 1'b1;
        @(negedge clk);
        rst = 1'b1; strobe = 1'b1; ready = 1'b1;
        cyc(2); rst = 1'b0;
        fork
            begin
                cyc(6); strobe = 1'b0; cyc(3); strobe = 1'b1; cyc(2); strobe = 1'b0;
            end
            begin
                for (int k = 0; k < 16 + D; k++) begin
                    @(negedge clk);
                    if (a_valid) begin nv++; w = a_width; f = a_first; s = a_sat; end
                end
            end
        join
        n_tests++;
        if (nv !== 1) begin n_fail++; $display("FAIL rsthigh_count: got %0d want 1", nv); end
        n_tests++;
        if (w !== 16'd2) begin n_fail++; $display("FAIL rsthigh_width: got %0d want 2", w); end
        n_tests++;
        if (f !== 1'b1) begin n_fail++; $display("FAIL rsthigh_first: got %b want 1", f); end
        n_tests++;
        if (s !== 1'b0) begin n_fail++; $display("FAIL rsthigh_sat: got %b want 0", s); end
        // reset in the middle of a pulse abandons it
        strobe = 1'b1; cyc(3);
        rst = 1'b1; cyc(1); strobe = 1'b0; rst = 1'b0;
        for (int k = 0; k < 8 + D; k++) begin
            @(negedge clk);
            if (a_valid) nv2++;
        end
        n_tests++;
        if (nv2 !== 0) begin n_fail++; $display("FAIL midreset_count: got %0d want 0", nv2); end
        strobe = 1'b1; cyc(2); strobe = 1'b0; cyc(D + 2);
        n_tests++;
        if ({a_valid, a_first} !== 2'b11) begin
            n_fail++; $display("FAIL midreset_rearm: got valid,first=%b want 11", {a_valid, a_first});
        end
    endtask

    task automatic test_drop();
        int w1, w2;
        w1 = $urandom_range(2, 5);
        w2 = w1 + $urandom_range(1, 4);
        do_reset(1'b0);
        ready = 1'b0;
        cyc(3);
        strobe = 1'b1; cyc(w1); strobe = 1'b0; cyc(D + 3);
        n_tests++;
        if ({a_valid, a_width} !== {1'b1, 16'(w1)}) begin
            n_fail++; $display("FAIL drop_first_held: got valid=%b width=%0d want valid=1 width=%0d", a_valid, a_width, w1);
        end
        strobe = 1'b1; cyc(w2); strobe = 1'b0; cyc(D + 3);
        n_tests++;
        if ({a_valid, a_width, a_first} !== {1'b1, 16'(w1), 1'b1}) begin
            n_fail++; $display("FAIL drop_keep_old: got valid=%b width=%0d first=%b want 1 %0d 1", a_valid, a_width, a_first, w1);
        end
        n_tests++;
        if (a_drop !== 1'b1) begin n_fail++; $display("FAIL drop_flag: got %b want 1", a_drop); end
        ready = 1'b1; cyc(1);
        n_tests++;
        if (a_valid !== 1'b0) begin n_fail++; $display("FAIL drop_drain: got valid=%b want 0", a_valid); end
        n_tests++;
        if (a_drop !== 1'b1) begin n_fail++; $display("FAIL drop_sticky: got %b want 1", a_drop); end
    endtask

    task automatic test_accept_and_load();
        int w1, w2, g;
        w1 = $urandom_range(2, 5);
        w2 = w1 + $urandom_range(1, 4);
        g  = $urandom_range(1, 5);
        do_reset(1'b0);
        ready = 1'b0;
        cyc(2);
        strobe = 1'b1; cyc(w1); strobe = 1'b0; cyc(g);
        strobe = 1'b1; cyc(w2); strobe = 1'b0;
        n_tests++;
        if ({a_valid, a_width} !== {1'b1, 16'(w1)}) begin
            n_fail++; $display("FAIL al_hold: got valid=%b width=%0d want valid=1 width=%0d", a_valid, a_width, w1);
        end
        cyc(D + 1);
        ready = 1'b1;
        cyc(1);
        n_tests++;
        if ({a_valid, a_width, a_gap, a_first} !== {1'b1, 16'(w2), 16'(g), 1'b0}) begin
            n_fail++;
            $display("FAIL al_load: got valid=%b width=%0d gap=%0d first=%b want 1 %0d %0d 0", a_valid, a_width, a_gap, a_first, w2, g);
        end
        n_tests++;
        if (a_drop !== 1'b0) begin n_fail++; $display("FAIL al_drop: got %b want 0", a_drop); end
        cyc(1);
        n_tests++;
        if (a_valid !== 1'b0) begin n_fail++; $display("FAIL al_drain: got %b want 0", a_valid); end
    endtask

    task automatic test_sat_timeout();
        int bn, j;
        logic [3:0] bw;
        logic bs, bf, exp_to;
        bn = 0; bw = '0; bs = 1'b0; bf = 1'b0;
        do_reset(1'b0);
        cyc(4);
        strobe = 1'b1; cyc(20); strobe = 1'b0;
        for (int m = 1; m <= 14 + D; m++) begin
            @(negedge clk);
            j = m - 1 - D;
            exp_to = (j >= 10) && (j <= 11);
            n_tests++;
            if (b_timeout !== exp_to) begin
                n_fail++; $display("FAIL timeout[%0d]: got %b want %b", m, b_timeout, exp_to);
            end
            if (b_valid) begin bn++; bw = b_width; bs = b_sat; bf = b_first; end
            if (m == 12) strobe = 1'b1;
        end
        n_tests++;
        if (bn !== 1) begin n_fail++; $display("FAIL wsat_count: got %0d want 1", bn); end
        n_tests++;
        if ({bw, bs, bf} !== {4'd15, 1'b1, 1'b1}) begin
            n_fail++; $display("FAIL wsat_result: got width=%0d sat=%b first=%b want 15 1 1", bw, bs, bf);
        end
        strobe = 1'b0; cyc(D + 2);
        n_tests++;
        if ({b_valid, b_width, b_gap, b_sat} !== {1'b1, 4'(2 + D), 4'd12, 1'b0}) begin
            n_fail++;
            $display("FAIL after_to_result: got valid=%b width=%0d gap=%0d sat=%b want 1 %0d 12 0", b_valid, b_width, b_gap, b_sat, 2 + D);
        end
        cyc(16 - D);
        n_tests++;
        if (b_timeout !== 1'b1) begin n_fail++; $display("FAIL long_low_timeout: got %b want 1", b_timeout); end
        strobe = 1'b1; cyc(2); strobe = 1'b0; cyc(D + 2);
        n_tests++;
        if ({b_valid, b_width, b_gap, b_sat} !== {1'b1, 4'd2, 4'd15, 1'b1}) begin
            n_fail++;
            $display("FAIL gsat_result: got valid=%b width=%0d gap=%0d sat=%b want 1 2 15 1", b_valid, b_width, b_gap, b_sat);
        end
        n_tests++;
        if (b_timeout !== 1'b0) begin n_fail++; $display("FAIL timeout_idle_high: got %b want 0", b_timeout); end
    endtask

    initial begin
        test_reset();
        test_single_pulse();
        test_back_to_back();
        test_reset_high();
        test_drop();
        test_accept_and_load();
        test_sat_timeout();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #1000000;
        n_fail++;
        $display("FAIL watchdog: got no completion want completion within 1000000 time units");
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $fatal(1, "watchdog expired");
    end

endmodule
